// File: rtl/alu_cmd_sequencer.sv
// Byte-serial command sequencer for the project ALU: gathers opcode/operands,
// issues one ALU operation, waits for completion or timeout, returns the result.
module alu_cmd_sequencer #(
    parameter int WIDTH   = 8,
    parameter int OPW     = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_start,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    input  logic             alu_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_flags,
    output logic             out_err,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GET_A  = 3'd1,
        ST_GET_B  = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_OUTPUT = 3'd5
    } state_t;

    localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT - 1);

    state_t           state_r, next_state_s;
    logic [4:0]       cnt_r;
    logic [WIDTH-1:0] acc_r;
    logic [OPW-1:0]   alu_op_r;
    logic [WIDTH-1:0] alu_a_r, alu_b_r, out_data_r;
    logic [3:0]       out_flags_r;
    logic             out_err_r, err_r;
    logic             in_ready_r, alu_start_r, out_valid_r, busy_r;
    logic             in_ready_s, alu_start_s, out_valid_s, busy_s;
    logic             in_fire_s, use_acc_s, is_clr_s, wait_expired_s;
    logic             unused_bits_s;

    assign in_fire_s      = in_valid & in_ready_r;
    assign use_acc_s      = in_data[WIDTH-1];
    assign is_clr_s       = use_acc_s & (in_data[OPW-1:0] == {OPW{1'b1}});
    assign wait_expired_s = (cnt_r == TIMEOUT_LAST);
    assign unused_bits_s  = &{1'b0, in_data[WIDTH-2:OPW]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_fire_s && !is_clr_s) begin
                    next_state_s = use_acc_s ? ST_GET_B : ST_GET_A;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_GET_A: begin
                if (in_fire_s) next_state_s = ST_GET_B;
                else           next_state_s = ST_GET_A;
            end
            ST_GET_B: begin
                if (in_fire_s) next_state_s = ST_ISSUE;
                else           next_state_s = ST_GET_B;
            end
            ST_ISSUE: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (alu_done || wait_expired_s) next_state_s = ST_OUTPUT;
                else                            next_state_s = ST_WAIT;
            end
            ST_OUTPUT: begin
                if (out_ready) next_state_s = ST_IDLE;
                else           next_state_s = ST_OUTPUT;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below so outputs leave flops
    always_comb begin
        in_ready_s  = 1'b0;
        alu_start_s = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b1;
        case (next_state_s)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            ST_GET_A:  in_ready_s  = 1'b1;
            ST_GET_B:  in_ready_s  = 1'b1;
            ST_ISSUE:  alu_start_s = 1'b1;
            ST_WAIT:   busy_s      = 1'b1;
            ST_OUTPUT: out_valid_s = 1'b1;
            default:   busy_s      = 1'b1;
        endcase
    end

    // Control output registers (in_ready resets high because reset lands in IDLE)
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            alu_start_r <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_s;
            alu_start_r <= alu_start_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
        end
    end

    // Datapath: operand capture, accumulator, wait counter and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r       <= {WIDTH{1'b0}};
            alu_op_r    <= {OPW{1'b0}};
            alu_a_r     <= {WIDTH{1'b0}};
            alu_b_r     <= {WIDTH{1'b0}};
            cnt_r       <= 5'd0;
            out_data_r  <= {WIDTH{1'b0}};
            out_flags_r <= 4'd0;
            out_err_r   <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_fire_s) begin
                        alu_op_r <= in_data[OPW-1:0];
                        if (is_clr_s) begin
                            acc_r <= {WIDTH{1'b0}};
                        end else if (use_acc_s) begin
                            alu_a_r <= acc_r;
                        end
                    end
                end
                ST_GET_A: begin
                    if (in_fire_s) alu_a_r <= in_data;
                end
                ST_GET_B: begin
                    if (in_fire_s) alu_b_r <= in_data;
                end
                ST_ISSUE: cnt_r <= 5'd0;
                ST_WAIT: begin
                    // A done arriving on the last counted cycle still wins over the timeout
                    if (alu_done) begin
                        acc_r       <= alu_result;
                        out_data_r  <= alu_result;
                        out_flags_r <= alu_flags;
                        out_err_r   <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 5'd1;
                        if (wait_expired_s) begin
                            out_data_r  <= {WIDTH{1'b0}};
                            out_flags_r <= 4'd0;
                            out_err_r   <= 1'b1;
                            err_r       <= 1'b1;
                        end
                    end
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign alu_start = alu_start_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign alu_op    = alu_op_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign out_data  = out_data_r;
    assign out_flags = out_flags_r;
    assign out_err   = out_err_r;
    assign err       = err_r;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized self-checking bench for alu_cmd_sequencer; the bench also plays the ALU
// and keeps a command-level model of the accumulator and sticky error.
module tb_alu_cmd_sequencer;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [3:0] alu_op;
    logic [7:0] alu_a, alu_b;
    logic       alu_start;
    logic [7:0] alu_result = 8'h00;
    logic [3:0] alu_flags = 4'h0;
    logic       alu_done = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [3:0] out_flags;
    logic       out_err;
    logic       busy;
    logic       err;

    int total = 0;
    int bad   = 0;

    logic [7:0] acc_m = 8'h00;
    logic       err_m = 1'b0;

    alu_cmd_sequencer #(.WIDTH(8), .OPW(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
        .alu_result(alu_result), .alu_flags(alu_flags), .alu_done(alu_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .out_err(out_err), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ALU behaviour played by the bench
    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] v, input bit gap);
        int n;
        if (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            repeat ($urandom_range(0, 2)) tick();
        end
        in_valid = 1'b1;
        in_data  = v;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("in_ready_wait", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // delay: WAIT cycle (1..TO) on which done is given; anything else means never
    task automatic run_cmd(input logic [7:0] b0, input logic [7:0] a, input logic [7:0] b,
                           input int delay, input int bp, input bit early_done);
        logic       use_acc, done_seen, seen;
        logic [3:0] op, fl;
        logic [7:0] exp_a, res, exp_d;
        use_acc = b0[7];
        op      = b0[3:0];
        send_byte(b0, 1'b1);
        if (use_acc && op == 4'hF) begin
            acc_m = 8'h00;
            chk("clr_busy", busy, 0);
            seen = 1'b0;
            repeat (3) begin
                seen = seen | alu_start | out_valid | ~in_ready;
                tick();
            end
            chk("clr_quiet", seen, 0);
            return;
        end
        exp_a = use_acc ? acc_m : a;
        if (!use_acc) send_byte(a, 1'b1);
        send_byte(b, 1'b1);
        chk("start", alu_start, 1);
        chk("op", alu_op, op);
        chk("a", alu_a, exp_a);
        chk("b", alu_b, b);
        chk("rdy_issue", in_ready, 0);
        res = alu_fn(op, exp_a, b);
        fl  = {(res < exp_a), (res == 8'h00), res[7], 1'b0};
        if (early_done) begin
            alu_done   = 1'b1;
            alu_result = ~res;
            alu_flags  = 4'hF;
        end
        tick();
        alu_done = 1'b0;
        chk("start_pulse", alu_start, 0);
        done_seen = 1'b0;
        seen      = 1'b0;
        for (int k = 1; k <= TO && !done_seen; k++) begin
            seen = seen | out_valid | alu_start | (alu_a !== exp_a) | (alu_b !== b) | (alu_op !== op);
            if (k == delay) begin
                alu_done   = 1'b1;
                alu_result = res;
                alu_flags  = fl;
                done_seen  = 1'b1;
            end
            tick();
            alu_done   = 1'b0;
            alu_result = 8'($urandom);
            alu_flags  = 4'($urandom);
        end
        chk("wait_hold", seen, 0);
        if (done_seen) acc_m = res;
        else           err_m = 1'b1;
        exp_d = done_seen ? res : 8'h00;
        chk("valid", out_valid, 1);
        chk("data", out_data, exp_d);
        chk("flags", out_flags, done_seen ? fl : 4'h0);
        chk("out_err", out_err, !done_seen);
        chk("err", err, err_m);
        seen = 1'b0;
        repeat (bp) begin
            tick();
            seen = seen | ~out_valid | (out_data !== exp_d) | in_ready;
        end
        chk("bp_hold", seen, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("rel_valid", out_valid, 0);
        chk("rel_ready", in_ready, 1);
        chk("rel_busy", busy, 0);
        chk("a_retain", alu_a, exp_a);
    endtask

    task automatic reset_in_wait();
        send_byte(8'h00, 1'b0);
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        acc_m = 8'h00;
        err_m = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_data", out_data, 0);
        alu_done   = 1'b1;
        alu_result = 8'hAA;
        tick();
        alu_done = 1'b0;
        tick();
        chk("late_done_valid", out_valid, 0);
        chk("late_done_busy", busy, 0);
    endtask

    initial begin
        logic [7:0] b0;
        int dly;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("init_busy", busy, 0);
        chk("init_valid", out_valid, 0);
        chk("init_start", alu_start, 0);
        chk("init_err", err, 0);
        chk("init_ready", in_ready, 1);
        chk("init_data", out_data, 0);

        run_cmd(8'h00, 8'h12, 8'h34, 2, 0, 1'b0);
        chk("t1_acc", acc_m, 8'h46);
        run_cmd(8'h80, 8'h00, 8'h01, 2, 0, 1'b0);
        chk("t2_acc", acc_m, 8'h47);
        run_cmd(8'h01, 8'h50, 8'h10, 3, 5, 1'b0);
        run_cmd(8'h80, 8'h00, 8'h05, 99, 2, 1'b0);
        run_cmd(8'h80, 8'h00, 8'h01, 1, 0, 1'b1);
        run_cmd(8'h8F, 8'h00, 8'h00, 0, 0, 1'b0);
        run_cmd(8'h80, 8'h00, 8'h09, TO, 1, 1'b1);
        reset_in_wait();
        run_cmd(8'h80, 8'h00, 8'h03, 4, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            b0  = 8'($urandom);
            dly = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TO));
            run_cmd(b0, 8'($urandom), 8'($urandom), dly, int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
